// File: rtl/pulse_capture_counter.sv
// Input-capture timer: measures the period or pulse width of an external
// signal in counts of the ena tick, with timeout, overrun and valid/ack.
module pulse_capture_counter #(
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic            sig,
    input  logic [1:0]      mode,
    input  logic            oneshot,
    input  logic            start,
    input  logic            stop,
    input  logic [BITS-1:0] top,
    input  logic            ack,
    output logic [BITS-1:0] capture,
    output logic            valid,
    output logic            ovr,
    output logic            tmo,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [BITS-1:0] cnt;
    logic [BITS-1:0] cnt_n;
    logic [BITS-1:0] cnt_one;

    logic s1;
    logic s2;
    logic p;
    logic rise;
    logic fall;
    logic start_edge;
    logic end_edge;
    logic period;
    logic ctl;
    logic in_meas;
    logic cap_evt;
    logic tmo_evt;

    // Two-flop synchroniser plus one flop of history for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            p  <= 1'b0;
        end else begin
            s1 <= sig;
            s2 <= s1;
            p  <= s2;
        end
    end

    assign rise = s2 & ~p;
    assign fall = ~s2 & p;

    // Modes 01/11 start on a falling edge; 01/10 end on a falling edge
    assign start_edge = mode[0] ? fall : rise;
    assign end_edge   = (mode[1] ^ mode[0]) ? fall : rise;
    assign period     = ~mode[1];

    assign cnt_one = {{(BITS-1){1'b0}}, ena};
    assign ctl     = ~stop & ~start;
    assign in_meas = (state == MEASURE);

    // An end edge beats a timeout in the same cycle; >= keeps it wrap-free
    assign cap_evt = in_meas & end_edge & ctl;
    assign tmo_evt = in_meas & ena & (cnt >= top) & ~end_edge & ctl;

    // Next state and next count; stop beats start, start beats edges
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (stop) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (start) begin
            state_n = ARMED;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = IDLE;
                end
                ARMED: begin
                    if (start_edge) begin
                        state_n = MEASURE;
                        cnt_n   = cnt_one;
                    end
                end
                MEASURE: begin
                    if (end_edge) begin
                        if (oneshot) begin
                            state_n = IDLE;
                            cnt_n   = '0;
                        end else if (period) begin
                            cnt_n = cnt_one;
                        end else begin
                            state_n = ARMED;
                            cnt_n   = '0;
                        end
                    end else if (tmo_evt) begin
                        state_n = oneshot ? IDLE : ARMED;
                        cnt_n   = '0;
                    end else if (ena) begin
                        cnt_n = cnt + BITS'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Control state, tick counter and registered busy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            busy  <= (state_n != IDLE);
        end
    end

    // Result register and status flags; a fresh event outranks ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            capture <= '0;
            valid   <= 1'b0;
            ovr     <= 1'b0;
            tmo     <= 1'b0;
        end else begin
            if (cap_evt) begin
                capture <= cnt;
            end

            if (cap_evt) begin
                valid <= 1'b1;
            end else if (ack) begin
                valid <= 1'b0;
            end

            if (cap_evt && valid && !ack) begin
                ovr <= 1'b1;
            end else if (ack) begin
                ovr <= 1'b0;
            end

            if (tmo_evt) begin
                tmo <= 1'b1;
            end else if (ack) begin
                tmo <= 1'b0;
            end
        end
    end

endmodule
